// File: rtl/rt_pixel_scheduler.sv
// Raster-order pixel job scheduler feeding two ray-tracing lanes, then
// re-serialising their results into an in-order fragment stream.
module rt_pixel_scheduler #(
    parameter int IW      = 16,
    parameter int QW      = 16,
    parameter int MAX_OUT = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [31:0]   image_width,
    input  logic [31:0]   image_height,
    output logic          busy,
    output logic          done,
    output logic [1:0]    job_valid,
    input  logic [1:0]    job_ready,
    output logic [IW-1:0] job_x,
    output logic [IW-1:0] job_y,
    input  logic [1:0]    res_valid,
    output logic [1:0]    res_ready,
    input  logic [63:0]   res_data,
    output logic          valid,
    input  logic          ready,
    output logic [31:0]   fragment,
    output logic          last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [IW-1:0] w;
    logic [IW-1:0] h;
    logic [IW-1:0] w_in;
    logic [IW-1:0] h_in;
    logic [IW-1:0] cx;
    logic [IW-1:0] cy;
    logic          dptr;
    logic          cptr;
    logic [2:0]    outst [2];

    logic          start_ok;
    logic          start_empty;
    logic          accept;
    logic          pop;
    logic          out_fire;
    logic          last_fire;
    logic          dispatch_end;
    logic          collect_end;
    logic [31:0]   pop_data;

    assign w_in = IW'(image_width >> QW);
    assign h_in = IW'(image_height >> QW);
    assign busy = (state != S_IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch can be inferred.
        job_valid    = '0;
        res_ready    = '0;
        start_ok     = (state == S_IDLE) && start;
        start_empty  = (w_in == '0) || (h_in == '0);
        if (state == S_RUN && outst[dptr] < 3'(MAX_OUT)) begin
            job_valid[dptr] = 1'b1;
        end
        accept       = |(job_valid & job_ready);
        // Only the lane whose turn it is may pop, and only if the output slot frees up.
        if (state != S_IDLE && res_valid[cptr] && (!valid || ready)) begin
            res_ready[cptr] = 1'b1;
        end
        pop          = |res_ready;
        pop_data     = cptr ? res_data[63:32] : res_data[31:0];
        out_fire     = valid && ready;
        last_fire    = out_fire && last;
        dispatch_end = (job_x == w - IW'(1)) && (job_y == h - IW'(1));
        collect_end  = (cx == w - IW'(1)) && (cy == h - IW'(1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok && !start_empty) state_nxt = S_RUN;
            S_RUN:   if (accept && dispatch_end) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DRAIN;
            default: state_nxt = S_IDLE;
        endcase
        if (last_fire) begin
            state_nxt = S_IDLE;
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block rather than its sensitivity list.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w        <= '0;
            h        <= '0;
            job_x    <= '0;
            job_y    <= '0;
            cx       <= '0;
            cy       <= '0;
            dptr     <= 1'b0;
            cptr     <= 1'b0;
            outst    <= '{default: '0};
            valid    <= 1'b0;
            last     <= 1'b0;
            fragment <= '0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            done <= (start_ok && start_empty) || last_fire;

            if (start_ok) begin
                w     <= w_in;
                h     <= h_in;
                job_x <= '0;
                job_y <= '0;
                cx    <= '0;
                cy    <= '0;
                dptr  <= 1'b0;
                cptr  <= 1'b0;
            end

            if (accept) begin
                dptr <= ~dptr;
                if (job_x == w - IW'(1)) begin
                    job_x <= '0;
                    job_y <= job_y + IW'(1);
                end else begin
                    job_x <= job_x + IW'(1);
                end
            end

            if (pop) begin
                cptr     <= ~cptr;
                fragment <= pop_data;
                valid    <= 1'b1;
                last     <= collect_end;
                if (cx == w - IW'(1)) begin
                    cx <= '0;
                    cy <= cy + IW'(1);
                end else begin
                    cx <= cx + IW'(1);
                end
            end else if (out_fire) begin
                valid <= 1'b0;
                last  <= 1'b0;
            end

            // A same-lane accept and pop cancel out.
            for (int l = 0; l < 2; l++) begin
                if ((job_valid[l] && job_ready[l]) && !res_ready[l]) begin
                    outst[l] <= outst[l] + 3'd1;
                end else if (!(job_valid[l] && job_ready[l]) && res_ready[l]) begin
                    outst[l] <= outst[l] - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rt_pixel_scheduler.sv
// Directed bench for rt_pixel_scheduler: lane models with programmable return
// delay, a raster-order scoreboard and per-cycle handshake checks.
module tb_rt_pixel_scheduler;

    localparam int IW      = 16;
    localparam int MAX_OUT = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   image_width = '0;
    logic [31:0]   image_height = '0;
    logic          busy;
    logic          done;
    logic [1:0]    job_valid;
    logic [1:0]    job_ready = 2'b11;
    logic [IW-1:0] job_x;
    logic [IW-1:0] job_y;
    logic [1:0]    res_valid = '0;
    logic [1:0]    res_ready;
    logic [63:0]   res_data = '0;
    logic          valid;
    logic          ready = 1'b1;
    logic [31:0]   fragment;
    logic          last;

    always #5 clk = ~clk;

    rt_pixel_scheduler #(.IW(IW), .QW(16), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .image_width(image_width), .image_height(image_height),
        .busy(busy), .done(done),
        .job_valid(job_valid), .job_ready(job_ready), .job_x(job_x), .job_y(job_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .valid(valid), .ready(ready), .fragment(fragment), .last(last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model state
    int          cyc = 0;
    int          W = 0, H = 0, ex = 0, ey = 0, n = 0;
    bit          exp_dptr = 0, exp_cptr = 0;
    int          outst [2] = '{0, 0};
    bit          tb_busy = 0, exp_done_next = 0, exp_jv_first = 0, chk_reset = 0;
    bit          pop_prev = 0, hold_prev = 0, jv_pend = 0, any_jv = 0, start_req = 0;
    logic [31:0] pop_prev_data = '0, hold_frag = '0;
    logic        hold_last = 1'b0;
    logic [1:0]  jv_prev = '0;
    int          delay [2] = '{3, 3};
    int          hold0_until = 0, rdy_lo_from = -1, rdy_lo_to = -1;
    int          stall_probe = -1, spur_start = -1, jr_lo = -1;
    int          saw_l1_held = 0, saw_hold = 0;
    logic [7:0]  tag = 8'h00;
    int          lt0[$], lt1[$];
    logic [31:0] lp0[$], lp1[$];

    function automatic logic [31:0] payload(input int x, input int y);
        return {tag, 12'(y), 12'(x)};
    endfunction

    task automatic step();
        logic        cur_done;
        logic        cur_pop;
        logic [1:0]  rv;
        logic [1:0]  exp_rr;
        logic [31:0] d0, d1, pdata;
        @(negedge clk);
        cur_done      = exp_done_next;
        exp_done_next = 0;
        rv = '0; d0 = '0; d1 = '0; pdata = '0; cur_pop = 0;
        if (lt0.size() > 0 && lt0[0] <= cyc && cyc >= hold0_until) begin rv[0] = 1'b1; d0 = lp0[0]; end
        if (lt1.size() > 0 && lt1[0] <= cyc) begin rv[1] = 1'b1; d1 = lp1[0]; end
        res_valid = rv;
        res_data  = {d1, d0};
        ready     = !(cyc >= rdy_lo_from && cyc < rdy_lo_to);
        job_ready = (cyc == jr_lo) ? 2'b00 : 2'b11;
        start     = start_req || (cyc == spur_start);
        #1;
        if (resetn) begin
            if (chk_reset) begin
                chk_reset = 0;
                check("rst_busy", busy, 0);
                check("rst_jv", job_valid, 0);
                check("rst_rr", res_ready, 0);
                check("rst_valid", valid, 0);
                check("rst_last", last, 0);
                check("rst_frag", fragment, 0);
                check("rst_xy", {job_x, job_y}, 0);
            end
            check("done", done, cur_done);
            check("busy", busy, tb_busy);
            check("jv_onehot", $countones(job_valid) <= 1, 1);
            if (job_valid != 0) any_jv = 1;
            if (exp_jv_first) begin exp_jv_first = 0; check("start_lat", job_valid, 2'b01); end
            if (jv_pend) check("jv_hold", job_valid, jv_prev);
            if (cyc == stall_probe) begin
                check("stall_jv", job_valid, 0);
                check("stall_out0", outst[0], MAX_OUT);
            end
            for (int l = 0; l < 2; l++) begin
                if (job_valid[l]) begin
                    check("jv_lane", l, exp_dptr);
                    check("jv_limit", outst[l] < MAX_OUT, 1);
                    check("job_x", job_x, ex);
                    check("job_y", job_y, ey);
                end
            end
            jv_pend = 0;
            if (job_valid != 0) begin
                if ((job_valid & job_ready) != 0) begin
                    if (job_valid[0]) begin
                        lt0.push_back(cyc + delay[0]); lp0.push_back(payload(ex, ey)); outst[0]++;
                    end else begin
                        lt1.push_back(cyc + delay[1]); lp1.push_back(payload(ex, ey)); outst[1]++;
                    end
                    exp_dptr = !exp_dptr;
                    if (ex == W - 1) begin ex = 0; ey++; end else ex++;
                end else begin
                    jv_pend = 1; jv_prev = job_valid;
                end
            end

            exp_rr = '0;
            if (tb_busy && rv[exp_cptr] && (!valid || ready)) exp_rr[exp_cptr] = 1'b1;
            check("res_ready", res_ready, exp_rr);
            if (tb_busy && rv[1] && !exp_cptr) saw_l1_held++;
            if (res_ready[0] && rv[0]) begin
                void'(lt0.pop_front()); pdata = lp0.pop_front(); outst[0]--; cur_pop = 1;
            end else if (res_ready[1] && rv[1]) begin
                void'(lt1.pop_front()); pdata = lp1.pop_front(); outst[1]--; cur_pop = 1;
            end
            if (cur_pop) exp_cptr = !exp_cptr;

            if (pop_prev) begin
                check("pop_lat_v", valid, 1);
                check("pop_lat_d", fragment, pop_prev_data);
            end
            if (hold_prev) begin
                saw_hold++;
                check("hold_v", valid, 1);
                check("hold_d", fragment, hold_frag);
                check("hold_l", last, hold_last);
            end
            if (valid && ready) begin
                if (n < W * H) begin
                    check("frag", fragment, payload(n % W, n / W));
                    check("last", last, n == W * H - 1);
                    if (n == W * H - 1) begin exp_done_next = 1; tb_busy = 0; end
                end else begin
                    check("extra_frag", 1, 0);
                end
                n++;
            end
            hold_prev     = valid && !ready;
            hold_frag     = fragment;
            hold_last     = last;
            pop_prev      = cur_pop;
            pop_prev_data = pdata;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic begin_frame(input logic [31:0] wv, input logic [31:0] hv, input logic [7:0] tg);
        image_width  = wv;
        image_height = hv;
        tag          = tg;
        W            = int'(wv >> 16) & 32'hFFFF;
        H            = int'(hv >> 16) & 32'hFFFF;
        any_jv       = 0;
        start_req    = 1;
        step();
        start_req    = 0;
        ex = 0; ey = 0; n = 0; exp_dptr = 0; exp_cptr = 0;
        if (W != 0 && H != 0) begin tb_busy = 1; exp_jv_first = 1; end
        else exp_done_next = 1;
    endtask

    task automatic finish_frame(input int limit);
        for (int i = 0; i < limit && (tb_busy || n < W * H); i++) step();
        check("frame_end", !tb_busy && n == W * H, 1);
        step();
        step();
    endtask

    initial begin
        step();
        step();
        resetn    = 1'b1;
        chk_reset = 1;
        step();

        // 2x2 frame, lanes 3-cycle latency, one refused offer and an ignored start.
        spur_start = cyc + 5;
        jr_lo      = cyc + 2;
        begin_frame(32'h0002_0000, 32'h0002_0000, 8'h11);
        finish_frame(200);
        spur_start = -1; jr_lo = -1;

        // Lane1 returns pixel 1 long before lane0 returns pixel 0.
        delay[0] = 6; delay[1] = 1; saw_l1_held = 0;
        begin_frame(32'h0002_0000, 32'h0002_0000, 8'h22);
        finish_frame(200);
        check("l1_held", saw_l1_held > 0, 1);
        delay[0] = 3; delay[1] = 3;

        // Lane0 withholds results: dispatch must stall at MAX_OUT, then recover.
        hold0_until = cyc + 22;
        stall_probe = cyc + 13;
        begin_frame(32'h0004_0000, 32'h0002_0000, 8'h33);
        finish_frame(300);
        hold0_until = 0; stall_probe = -1;

        // Downstream backpressure for 10 cycles mid-frame.
        saw_hold    = 0;
        rdy_lo_from = cyc + 8;
        rdy_lo_to   = cyc + 18;
        begin_frame(32'h0004_0000, 32'h0002_0000, 8'h44);
        finish_frame(300);
        check("bp_seen", saw_hold >= 9, 1);
        rdy_lo_from = -1; rdy_lo_to = -1;

        // Zero width: no jobs, no fragments, immediate done.
        begin_frame(32'h0000_FFFF, 32'h0002_0000, 8'h55);
        finish_frame(20);
        check("zero_nojv", any_jv, 0);

        // Reset mid-frame, stale lane results ignored, then a fresh 3x1 frame.
        begin_frame(32'h0004_0000, 32'h0002_0000, 8'h66);
        for (int i = 0; i < 5; i++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        tb_busy = 0; exp_done_next = 0; pop_prev = 0; hold_prev = 0; jv_pend = 0;
        exp_jv_first = 0; exp_cptr = 0; exp_dptr = 0; outst = '{0, 0};
        chk_reset = 1;
        for (int i = 0; i < 6; i++) step();
        lt0.delete(); lt1.delete(); lp0.delete(); lp1.delete();
        begin_frame(32'h0003_0000, 32'h0001_0000, 8'h77);
        finish_frame(200);
        check("rst_frame_cnt", n, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rt_pixel_scheduler.md
RT_PIXEL_SCHEDULER -- requirements
Module: rt_pixel_scheduler

Interface
REQ-001 The block SHALL have parameter IW, default 16, giving the integer bits of a pixel coordinate.
REQ-002 The block SHALL have parameter QW, default 16, giving the fraction bits of the image_width/image_height inputs.
REQ-003 The block SHALL have parameter MAX_OUT, default 2, giving the outstanding-job limit per lane (1..4).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: frame start request, sampled in IDLE only.
REQ-007 The block SHALL have ports image_width and image_height, input, 32 bits each: frame dimensions in fixed point with QW fraction bits.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-010 The block SHALL have port job_valid, output, 2 bits: per-lane job offer.
REQ-011 The block SHALL have port job_ready, input, 2 bits: per-lane job accept.
REQ-012 The block SHALL have ports job_x and job_y, output, IW bits each: shared pixel coordinate bus.
REQ-013 The block SHALL have port res_valid, input, 2 bits: per-lane result available.
REQ-014 The block SHALL have port res_ready, output, 2 bits: per-lane result pop.
REQ-015 The block SHALL have port res_data, input, 64 bits: lane0 result in [31:0], lane1 result in [63:32].
REQ-016 The block SHALL have port valid, output, 1 bit: output fragment valid.
REQ-017 The block SHALL have port ready, input, 1 bit: downstream accept.
REQ-018 The block SHALL have port fragment, output, 32 bits: output fragment.
REQ-019 The block SHALL have port last, output, 1 bit: high with the final fragment of a frame.

Function
REQ-020 On start in IDLE, the block SHALL latch W = image_width>>QW and H = image_height>>QW, each truncated to IW bits, and enter RUN next cycle with busy=1.
REQ-021 If W==0 or H==0 at start, the block SHALL issue no jobs and no fragments, and SHALL pulse done (busy=0) on the cycle after start.
REQ-022 The block SHALL ignore start while busy.
REQ-023 States SHALL be IDLE -> RUN (dispatching) -> DRAIN (all jobs issued, collecting) -> IDLE.
REQ-024 Dispatch order SHALL be raster order: x increments first, then at x==W-1 x wraps to 0 and y increments.
REQ-025 Pixel index k SHALL go to lane k mod 2, via a dispatch pointer that toggles only on an accepted job.
REQ-026 At most one job_valid bit SHALL be high per cycle.
REQ-027 job_valid[lane] SHALL be high only in RUN when that lane's outstanding count < MAX_OUT.
REQ-028 job_x, job_y and job_valid SHALL stay stable until job_ready.
REQ-029 A job SHALL be accepted when job_valid[lane] & job_ready[lane] are both high; the lane's outstanding count then increments.
REQ-030 After the job for (W-1, H-1) is accepted, the state SHALL move to DRAIN.
REQ-031 Collection SHALL use a collect pointer starting at lane0 that toggles per popped result, so fragments leave in raster order.
REQ-032 A result that arrives on the non-pointed lane SHALL be held (res_ready=0) until its turn.
REQ-033 res_ready[ptr] SHALL be combinational: high when res_valid[ptr] & (!valid | ready), with the other bit 0.
REQ-034 A pop SHALL load fragment <= the lane's res_data slice and set valid=1 on the next edge, and SHALL decrement that lane's outstanding count.
REQ-035 The output stage SHALL hold valid and fragment stable until ready.
REQ-036 valid SHALL clear on ready when no new pop occurs.
REQ-037 A pop and an output handshake in the same cycle SHALL give full throughput (1 fragment/cycle).
REQ-038 A pop and a job accept on the same lane in the same cycle SHALL leave that lane's outstanding count unchanged.
REQ-039 last SHALL be 1 exactly with fragment number W*H-1 (counted by collect x/y counters); valid and last SHALL clear on its handshake.
REQ-040 On the handshake of the last fragment, the block SHALL pulse done, drop busy, and return to IDLE.
REQ-041 Latency from an accepted start to the first job_valid SHALL be 1 cycle.
REQ-042 Latency from a pop to valid SHALL be 1 cycle.

Reset
REQ-043 While resetn=0 at a clock edge, the block SHALL enter IDLE with busy=0, done=0, job_valid=0, res_ready=0, valid=0, last=0, fragment=0, job_x=job_y=0, all counters and pointers 0, and outstanding counts 0.
REQ-044 Reset mid-frame SHALL abandon the frame with no done pulse.
REQ-045 After reset mid-frame, results still presented by the lanes SHALL be ignored (res_ready=0) until the next start.

Verification
REQ-046 The bench SHALL drive a 2x2 image (0x00020000 each), lanes always ready, results returned 3 cycles later -> jobs (0,0)L0, (1,0)L1, (0,1)L0, (1,1)L1; 4 fragments in order; last on the 4th; done 1 cycle after its handshake.
REQ-047 The bench SHALL drive lane1 returning pixel 1 before lane0 returns pixel 0 -> res_ready[1]=0 until pixel 0 pops; output order stays 0,1.
REQ-048 The bench SHALL drive MAX_OUT=2 with lane0 never returning results -> lane0 job_valid stops after 2 outstanding; lane1 stalls at its turn; no deadlock once lane0 results resume.
REQ-049 The bench SHALL drive ready=0 for 10 cycles mid-frame -> valid/fragment held constant; no result lost; res_ready=0 while the output is full.
REQ-050 The bench SHALL drive width 0x0000FFFF (W=0) -> no job_valid, no valid, done pulses 1 cycle after start.
REQ-051 The bench SHALL assert resetn=0 for 1 cycle mid-frame, then restart a 3x1 frame -> all outputs at reset values; new frame produces exactly 3 fragments starting at (0,0).
